reg_write_arbiter: RTL and testbench

- Round-robin arbiter sharing the write port of a bank of 16-bit load-enable registers among several requesters (datapath units, control FSM, I/O).
- Each granted request produces exactly one single-cycle load pulse on one register.
- The winner's data is driven on a shared D bus, and the winner is acknowledged in the same cycle.
- Sits between requesters and the register bank; each register's D is driven by reg_d and its load by reg_load[i].

---
 rtl/reg_write_arbiter_pkg.sv | 45 ++++
 rtl/reg_write_arbiter_if.sv | 26 ++
 rtl/reg_write_arbiter_rr_priority_pick.sv | 22 ++
 rtl/reg_write_arbiter.sv | 84 ++++++++
 tb/tb_reg_write_arbiter.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register write arbiter: FSM states,
// one-hot decode and a round-robin search usable by any shared-resource picker.
package reg_write_arbiter_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int MAX_REQ    = 8;
   localparam int MAX_DEC    = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] id;
   } pick_t;

   function automatic logic [MAX_DEC-1:0] onehot16(input int unsigned idx);
      logic [MAX_DEC-1:0] res;
      res = '0;
      if (idx < MAX_DEC) res[idx[3:0]] = 1'b1;
      return res;
   endfunction

   // First set bit at or above ptr, wrapping modulo n.
   function automatic pick_t rr_search(input logic [MAX_REQ-1:0] req,
                                       input logic [2:0]         ptr,
                                       input int unsigned        n);
      pick_t       p;
      int unsigned idx;
      p = '0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         if (k < n && !p.valid) begin
            idx = ({29'd0, ptr} + k) % n;
            if (req[idx[2:0]]) begin
               p.valid = 1'b1;
               p.id    = idx[2:0];
            end
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side and bank-side signals of the register write arbiter.
interface reg_write_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int NUM_REG = 8,
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 4
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        ack;
   logic [NUM_REG-1:0]        reg_load;
   logic [DATA_W-1:0]         reg_d;
   logic                      busy;
   logic                      err;

   modport master (
      output req, req_addr, req_data,
      input  ack, reg_load, reg_d, busy, err
   );

   modport slave (
      input  req, req_addr, req_data,
      output ack, reg_load, reg_d, busy, err
   );
endinterface

// File: rtl/reg_write_arbiter_rr_priority_pick.sv
// Combinational round-robin winner selection; reusable for any shared resource.
module rr_priority_pick
   import reg_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    id,
   output logic               valid
);

   pick_t p;

   always_comb begin
      p     = rr_search(MAX_REQ'(req), 3'(ptr), NUM_REQ);
      id    = ID_W'(p.id);
      valid = p.valid;
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the shared write port of a load-enable register bank.
// Two-state FSM: IDLE arbitrates, WRITE presents one registered load pulse.
module reg_write_arbiter
   import reg_write_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int NUM_REG = 8,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ADDR_W  = 4
) (
   input logic               clk,
   input logic               rst,
   reg_write_arbiter_if.slave bus
);

   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   lat_id;
   logic [ID_W-1:0]   w_id;
   logic              w_valid;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic              w_in_range;
   logic [15:0]       addr_dec;
   logic [15:0]       id_dec;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req   (bus.req),
      .ptr   (rr_ptr),
      .id    (w_id),
      .valid (w_valid)
   );

   always_comb begin
      w_addr     = bus.req_addr[32'(w_id)*ADDR_W +: ADDR_W];
      w_data     = bus.req_data[32'(w_id)*DATA_W +: DATA_W];
      w_in_range = (32'(w_addr) < NUM_REG);
      addr_dec   = onehot16(32'(w_addr));
      id_dec     = onehot16(32'(w_id));
   end

   // Outputs are loaded on the IDLE->WRITE edge so they are visible during WRITE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         lat_id       <= '0;
         bus.ack      <= '0;
         bus.reg_load <= '0;
         bus.reg_d    <= '0;
         bus.busy     <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (w_valid) begin
                  state        <= WRITE;
                  lat_id       <= w_id;
                  bus.ack      <= NUM_REQ'(id_dec);
                  bus.reg_load <= w_in_range ? NUM_REG'(addr_dec) : '0;
                  bus.err      <= !w_in_range;
                  bus.reg_d    <= w_data;
                  bus.busy     <= 1'b1;
               end
            end
            WRITE: begin
               state        <= IDLE;
               rr_ptr       <= (lat_id == ID_W'(NUM_REQ - 1)) ? '0 : lat_id + 1'b1;
               bus.ack      <= '0;
               bus.reg_load <= '0;
               bus.err      <= 1'b0;
               bus.busy     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a behavioural model of the register bank.
module tb_reg_write_arbiter;

   localparam int NUM_REQ = 4;
   localparam int NUM_REG = 8;
   localparam int DATA_W  = 16;
   localparam int ADDR_W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   logic [DATA_W-1:0] bank [NUM_REG];
   logic [DATA_W-1:0] snap [NUM_REG];

   reg_write_arbiter_if #(
      .NUM_REQ (NUM_REQ),
      .NUM_REG (NUM_REG),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
   ) bus ();

   reg_write_arbiter #(
      .NUM_REQ (NUM_REQ),
      .NUM_REG (NUM_REG),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Register bank: reset dominates load.
   always @(posedge clk) begin
      for (int i = 0; i < NUM_REG; i++) begin
         if (rst) bank[i] <= '0;
         else if (bus.reg_load[i]) bank[i] <= bus.reg_d;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bus.req[k] = 1'b1;
      bus.req_addr[k*ADDR_W +: ADDR_W] = a;
      bus.req_data[k*DATA_W +: DATA_W] = d;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ack"},  32'(bus.ack), 32'h0);
      check({tag, "_load"}, 32'(bus.reg_load), 32'h0);
      check({tag, "_busy"}, 32'(bus.busy), 32'h0);
      check({tag, "_err"},  32'(bus.err), 32'h0);
   endtask

   initial begin
      bus.req      = '0;
      bus.req_addr = '0;
      bus.req_data = '0;

      // Reset
      rst = 1'b1;
      step(); step();
      check_quiet("rst");
      check("rst_d", 32'(bus.reg_d), 32'h0);
      rst = 1'b0;

      // Single requester
      set_req(2, 4'd5, 16'h1234);
      step();
      check("single_ack",  32'(bus.ack), 32'h4);
      check("single_load", 32'(bus.reg_load), 32'h20);
      check("single_d",    32'(bus.reg_d), 32'h1234);
      check("single_busy", 32'(bus.busy), 32'h1);
      check("single_err",  32'(bus.err), 32'h0);
      bus.req[2] = 1'b0;
      step();
      check_quiet("single_after");
      check("single_hold_d", 32'(bus.reg_d), 32'h1234);
      check("single_reg5",   32'(bank[5]), 32'h1234);

      // Simultaneous requests from reset: order 0,1,3
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_req(0, 4'd1, 16'h1111);
      set_req(1, 4'd2, 16'h2222);
      set_req(3, 4'd7, 16'h3333);
      step();
      check("sim0_ack",  32'(bus.ack), 32'h1);
      check("sim0_load", 32'(bus.reg_load), 32'h02);
      check("sim0_d",    32'(bus.reg_d), 32'h1111);
      bus.req[0] = 1'b0;
      step();
      check("sim_gap1_ack", 32'(bus.ack), 32'h0);
      step();
      check("sim1_ack",  32'(bus.ack), 32'h2);
      check("sim1_load", 32'(bus.reg_load), 32'h04);
      check("sim1_d",    32'(bus.reg_d), 32'h2222);
      bus.req[1] = 1'b0;
      step();
      check("sim_gap2_ack", 32'(bus.ack), 32'h0);
      step();
      check("sim3_ack",  32'(bus.ack), 32'h8);
      check("sim3_load", 32'(bus.reg_load), 32'h80);
      check("sim3_d",    32'(bus.reg_d), 32'h3333);
      bus.req[3] = 1'b0;
      step();
      check("sim_reg1", 32'(bank[1]), 32'h1111);
      check("sim_reg2", 32'(bank[2]), 32'h2222);
      check("sim_reg7", 32'(bank[7]), 32'h3333);

      // Fairness: all four held for 16 cycles, pointer is back at 0
      set_req(0, 4'd0, 16'h0A00);
      set_req(1, 4'd1, 16'h0A01);
      set_req(2, 4'd2, 16'h0A02);
      set_req(3, 4'd3, 16'h0A03);
      begin
         int acks;
         acks = 0;
         for (int c = 1; c <= 16; c++) begin
            step();
            if (c % 2 == 1) check("fair_ack", 32'(bus.ack), 32'(1) << (((c - 1) / 2) % 4));
            else            check("fair_gap", 32'(bus.ack), 32'h0);
            if (bus.ack != '0) acks++;
         end
         check("fair_count", 32'(acks), 32'd8);
      end
      bus.req = '0;
      step();
      check("fair_reg3", 32'(bank[3]), 32'h0A03);

      // Out-of-range address
      for (int i = 0; i < NUM_REG; i++) snap[i] = bank[i];
      set_req(1, 4'd12, 16'hFFFF);
      step();
      check("oor_ack",  32'(bus.ack), 32'h2);
      check("oor_err",  32'(bus.err), 32'h1);
      check("oor_load", 32'(bus.reg_load), 32'h0);
      check("oor_busy", 32'(bus.busy), 32'h1);
      bus.req[1] = 1'b0;
      step();
      check("oor_err_clr", 32'(bus.err), 32'h0);
      begin
         int changed;
         changed = 0;
         for (int i = 0; i < NUM_REG; i++) if (bank[i] !== snap[i]) changed++;
         check("oor_bank", 32'(changed), 32'd0);
      end

      // Latching: data change after sampling is ignored (pointer at 2, wraps to 0)
      set_req(0, 4'd4, 16'hAAAA);
      step();
      bus.req_data[0 +: DATA_W] = 16'h5555;
      check("latch_ack", 32'(bus.ack), 32'h1);
      check("latch_d",   32'(bus.reg_d), 32'hAAAA);
      bus.req[0] = 1'b0;
      step();
      check("latch_reg4", 32'(bank[4]), 32'hAAAA);

      // Reset during WRITE (pointer at 1, so requester 3 wins)
      set_req(3, 4'd3, 16'hBEEF);
      step();
      check("rstw_ack",  32'(bus.ack), 32'h8);
      check("rstw_load", 32'(bus.reg_load), 32'h08);
      rst = 1'b1;
      bus.req = '0;
      step();
      check("rstw_reg3", 32'(bank[3]), 32'h0);
      check_quiet("rstw_after");
      check("rstw_d", 32'(bus.reg_d), 32'h0);
      rst = 1'b0;
      set_req(0, 4'd0, 16'h0001);
      set_req(1, 4'd1, 16'h0002);
      set_req(2, 4'd2, 16'h0003);
      set_req(3, 4'd6, 16'h0004);
      step();
      check("rstw_next_ack", 32'(bus.ack), 32'h1);
      bus.req = '0;
      step();

      // Reset in IDLE with req high: no grant while rst is held
      rst = 1'b1;
      set_req(2, 4'd6, 16'h7777);
      step();
      check("rsti_ack", 32'(bus.ack), 32'h0);
      rst = 1'b0;
      step();
      check("rsti_grant", 32'(bus.ack), 32'h4);
      check("rsti_load",  32'(bus.reg_load), 32'h40);
      bus.req = '0;
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
